alu_mdu: RTL and testbench



---
 rtl/alu_mdu_pkg.sv | 25 ++
 rtl/alu_mdu_engine.sv | 87 ++++++++
 rtl/alu_mdu.sv | 121 ++++++++++++
 tb/tb_alu_mdu.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/alu_mdu_pkg.sv
// Shared op-code encodings and width defaults for the rvseed execute unit.
package alu_mdu_pkg;
    localparam int XLEN_DEF = 32;
    localparam int OP_W     = 5;

    localparam int ALU_AND  = 0;
    localparam int ALU_OR   = 1;
    localparam int ALU_XOR  = 2;
    localparam int ALU_ADD  = 3;
    localparam int ALU_SUB  = 4;
    localparam int ALU_SLL  = 5;
    localparam int ALU_SRL  = 6;
    localparam int ALU_SRA  = 7;
    localparam int ALU_SLT  = 8;
    localparam int ALU_SLTU = 9;

    localparam int MD_MUL    = 16;
    localparam int MD_MULH   = 17;
    localparam int MD_MULHSU = 18;
    localparam int MD_MULHU  = 19;
    localparam int MD_DIV    = 20;
    localparam int MD_DIVU   = 21;
    localparam int MD_REM    = 22;
    localparam int MD_REMU   = 23;
endpackage

// File: rtl/alu_mdu_engine.sv
// Radix-2 iterative multiply/divide datapath: shift-add multiply, restoring divide,
// both on operand magnitudes with a sign fix applied to the last iteration's value.
module mdu_iter_engine
    import alu_mdu_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int OP_WIDTH = OP_W,
    parameter int SHW      = $clog2(XLEN)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                kill,
    input  logic                start,
    input  logic [OP_WIDTH-1:0] op,
    input  logic [XLEN-1:0]     a,
    input  logic [XLEN-1:0]     b,
    output logic                busy,
    output logic                done,
    output logic [XLEN-1:0]     result
);
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_b;
    logic [SHW-1:0]    r_cnt;
    logic              r_busy, r_div, r_hi, r_rem, r_negq, r_negr;

    logic              w_s1, w_s2, w_a_neg, w_b_neg;
    logic [XLEN-1:0]   w_a_mag, w_b_mag, w_q, w_r;
    logic [XLEN:0]     w_sum;
    logic [XLEN+1:0]   w_trial;
    logic [2*XLEN-1:0] w_nxt, w_p;

    assign w_s1 = (int'(op) == MD_MULH) || (int'(op) == MD_MULHSU) ||
                  (int'(op) == MD_DIV)  || (int'(op) == MD_REM);
    assign w_s2 = (int'(op) == MD_MULH) || (int'(op) == MD_DIV) || (int'(op) == MD_REM);
    assign w_a_neg = w_s1 & a[XLEN-1];
    assign w_b_neg = w_s2 & b[XLEN-1];
    assign w_a_mag = w_a_neg ? -a : a;
    assign w_b_mag = w_b_neg ? -b : b;

    // Multiply: low half of acc holds the unconsumed multiplier bits.
    assign w_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
    // Divide: acc = {remainder, quotient}; trial-subtract with borrow detect.
    assign w_trial = {1'b0, r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]} - {2'b00, r_b};
    assign w_nxt   = !r_div ? {w_sum, r_acc[XLEN-1:1]} :
                     (|w_trial[XLEN+1:XLEN]) ? {r_acc[2*XLEN-2:0], 1'b0} :
                     {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

    assign w_p = r_negq ? -w_nxt : w_nxt;
    assign w_q = r_negq ? -w_nxt[XLEN-1:0] : w_nxt[XLEN-1:0];
    assign w_r = r_negr ? -w_nxt[2*XLEN-1:XLEN] : w_nxt[2*XLEN-1:XLEN];

    assign result = !r_div ? (r_hi ? w_p[2*XLEN-1:XLEN] : w_p[XLEN-1:0]) :
                    (r_rem ? w_r : w_q);
    assign busy   = r_busy;
    assign done   = r_busy && (r_cnt == SHW'(XLEN-1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_b    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_div  <= 1'b0;
            r_hi   <= 1'b0;
            r_rem  <= 1'b0;
            r_negq <= 1'b0;
            r_negr <= 1'b0;
        end else if (kill) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (start) begin
            r_acc  <= {{XLEN{1'b0}}, w_a_mag};
            r_b    <= w_b_mag;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            r_div  <= (int'(op) >= MD_DIV);
            r_hi   <= (int'(op) != MD_MUL);
            r_rem  <= (int'(op) == MD_REM) || (int'(op) == MD_REMU);
            r_negq <= w_a_neg ^ w_b_neg;
            r_negr <= w_a_neg;
        end else if (r_busy) begin
            r_acc <= w_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (done) r_busy <= 1'b0;
        end
    end
endmodule

// File: rtl/alu_mdu.sv
// EX-stage execute unit: single-cycle integer ALU plus iterative RV-M multiply/divide,
// valid/ready handshakes on both sides so EX stalls while a long op runs.
module alu_mdu
    import alu_mdu_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int OP_WIDTH = OP_W,
    parameter int SHW      = $clog2(XLEN)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OP_WIDTH-1:0] op,
    input  logic [XLEN-1:0]     src1,
    input  logic [XLEN-1:0]     src2,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     res,
    output logic                zero
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_res;
    logic            r_zero, r_out_valid;

    logic [XLEN-1:0] w_res_1c, w_eng_res;
    logic [SHW-1:0]  w_shamt;
    logic            w_is_mul, w_is_dr, w_div0, w_ovf, w_special;
    logic            w_eng_start, w_eng_busy, w_eng_done;

    assign w_shamt   = src2[SHW-1:0];
    assign w_is_mul  = (int'(op) >= MD_MUL) && (int'(op) <= MD_MULHU);
    assign w_is_dr   = (int'(op) >= MD_DIV) && (int'(op) <= MD_REMU);
    assign w_div0    = (src2 == '0);
    assign w_ovf     = ((int'(op) == MD_DIV) || (int'(op) == MD_REM)) &&
                       (src1 == {1'b1, {(XLEN-1){1'b0}}}) && (&src2);
    assign w_special = w_is_dr && (w_div0 || w_ovf);

    // Div/rem rows only matter on the special (div-by-zero / overflow) path.
    always_comb begin
        w_res_1c = '0;
        case (int'(op))
            ALU_AND:          w_res_1c = src1 & src2;
            ALU_OR:           w_res_1c = src1 | src2;
            ALU_XOR:          w_res_1c = src1 ^ src2;
            ALU_ADD:          w_res_1c = src1 + src2;
            ALU_SUB:          w_res_1c = src1 - src2;
            ALU_SLL:          w_res_1c = src1 << w_shamt;
            ALU_SRL:          w_res_1c = src1 >> w_shamt;
            ALU_SRA:          w_res_1c = $unsigned($signed(src1) >>> w_shamt);
            ALU_SLT:          w_res_1c = XLEN'($signed(src1) < $signed(src2));
            ALU_SLTU:         w_res_1c = XLEN'(src1 < src2);
            MD_DIV, MD_DIVU:  w_res_1c = w_div0 ? '1 : src1;
            MD_REM, MD_REMU:  w_res_1c = w_div0 ? src1 : '0;
            default:          w_res_1c = '0;
        endcase
    end

    assign w_eng_start = (r_state == S_IDLE) && in_valid && !flush &&
                         (w_is_mul || (w_is_dr && !w_special));

    mdu_iter_engine #(.XLEN(XLEN), .OP_WIDTH(OP_WIDTH), .SHW(SHW)) u_engine (
        .clk    (clk),
        .rst_n  (rst_n),
        .kill   (flush),
        .start  (w_eng_start),
        .op     (op),
        .a      (src1),
        .b      (src2),
        .busy   (w_eng_busy),
        .done   (w_eng_done),
        .result (w_eng_res)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_res       <= '0;
            r_zero      <= 1'b1;
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
                    if (w_is_mul) r_state <= S_MUL;
                    else if (w_is_dr && !w_special) r_state <= S_DIV;
                    else begin
                        r_res       <= w_res_1c;
                        r_zero      <= (w_res_1c == '0);
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_MUL, S_DIV: begin
                    if (w_eng_done) begin
                        r_res       <= w_eng_res;
                        r_zero      <= (w_eng_res == '0);
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (!w_eng_busy) begin
                        r_state <= S_IDLE;
                    end
                end
                S_DONE: if (out_ready) begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign res       = r_res;
    assign zero      = r_zero;
endmodule

// File: tb/tb_alu_mdu.sv
// Directed vector bench for alu_mdu: table of ops with hand-computed results and latencies,
// plus sequences for backpressure, flush and mid-operation reset.
module tb_alu_mdu;
    import alu_mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  op = '0;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] res;
    logic        zero;

    int total = 0;
    int bad = 0;

    typedef struct {
        int          op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        int          lat;
    } vec_t;
    vec_t vq[$];

    alu_mdu dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .src1(src1), .src2(src2), .out_valid(out_valid), .out_ready(out_ready),
        .res(res), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input int lat);
        vec_t v;
        v.op = o; v.a = a; v.b = b; v.r = r; v.lat = lat;
        vq.push_back(v);
    endtask

    // Issue one op with out_ready high; returns the cycle on which out_valid appeared.
    task automatic issue(input int o, input logic [31:0] a, input logic [31:0] b, output int n);
        in_valid = 1'b1; op = 5'(o); src1 = a; src2 = b;
        tick();
        in_valid = 1'b0; src1 = 32'hDEADBEEF; src2 = 32'h0BADF00D;
        n = 1;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        logic seen;

        add(ALU_ADD,   32'd7,        32'hFFFFFFFD, 32'd4,        1);
        add(ALU_SUB,   32'd5,        32'd5,        32'd0,        1);
        add(ALU_AND,   32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1);
        add(ALU_OR,    32'hF0000000, 32'h0000000F, 32'hF000000F, 1);
        add(ALU_XOR,   32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 1);
        add(ALU_SLL,   32'd1,        32'h00000024, 32'h00000010, 1);
        add(ALU_SRL,   32'h80000000, 32'd31,       32'd1,        1);
        add(ALU_SRA,   32'h80000000, 32'd4,        32'hF8000000, 1);
        add(ALU_SLT,   32'hFFFFFFFF, 32'd1,        32'd1,        1);
        add(ALU_SLTU,  32'hFFFFFFFF, 32'd1,        32'd0,        1);
        add(10,        32'd3,        32'd4,        32'd0,        1);
        add(MD_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33);
        add(MD_MUL,    32'h80000000, 32'h80000000, 32'h00000000, 33);
        add(MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        add(MD_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33);
        add(MD_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        add(MD_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
        add(MD_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
        add(MD_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33);
        add(MD_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        33);
        add(MD_DIVU,   32'd100,      32'd7,        32'd14,       33);
        add(MD_REMU,   32'd100,      32'd7,        32'd2,        33);
        add(MD_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'd0,        33);
        add(MD_REMU,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);
        add(MD_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1);
        add(MD_REMU,   32'd9,        32'd0,        32'd9,        1);
        add(MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        add(MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

        // reset state
        tick(); tick();
        rst_n = 1'b1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_res", res, 32'd0);
        chk("rst_zero", 32'(zero), 32'd1);

        foreach (vq[i]) begin
            issue(vq[i].op, vq[i].a, vq[i].b, n);
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("v%0d_lat", i), 32'(n), 32'(vq[i].lat));
            chk($sformatf("v%0d_res", i), res, vq[i].r);
            chk($sformatf("v%0d_zero", i), 32'(zero), 32'(vq[i].r == 32'd0));
            tick();
            chk($sformatf("v%0d_idle", i), {30'd0, in_ready, out_valid}, 32'd2);
        end

        // backpressure: result held, new requests ignored
        out_ready = 1'b0;
        issue(ALU_ADD, 32'd1, 32'd1, n);
        chk("bp_lat", 32'(n), 32'd1);
        in_valid = 1'b1; op = 5'(ALU_ADD); src1 = 32'd9; src2 = 32'd9;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("bp_hold%0d", k), {res[29:0], in_ready, out_valid}, {30'd2, 1'b0, 1'b1});
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("bp_release", {30'd0, in_ready, out_valid}, 32'd2);

        // flush during DIVU at cycle 10
        in_valid = 1'b1; op = 5'(MD_DIVU); src1 = 32'd100; src2 = 32'd7;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k < 10; k++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_idle", {30'd0, in_ready, out_valid}, 32'd2);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("flush_no_result", 32'(seen), 32'd0);

        // flush coincident with accept discards the request
        in_valid = 1'b1; flush = 1'b1; op = 5'(ALU_ADD); src1 = 32'd3; src2 = 32'd3;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_accept", {30'd0, in_ready, out_valid}, 32'd2);

        // reset in the middle of a multiply (res is 2 from the backpressure op)
        in_valid = 1'b1; op = 5'(MD_MUL); src1 = 32'd6; src2 = 32'd7;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("mul_busy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        tick();
        chk("mrst_state", {30'd0, in_ready, out_valid}, 32'd2);
        chk("mrst_res", res, 32'd0);
        chk("mrst_zero", 32'(zero), 32'd1);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("mrst_no_result", 32'(seen), 32'd0);

        // unit still works afterwards
        issue(MD_MUL, 32'd6, 32'd7, n);
        chk("post_lat", 32'(n), 32'd33);
        chk("post_res", res, 32'd42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
